// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the 5-stage MIPS core.
// Registers the EX->MEM bus under stall control and aligns/extends load data
// from the synchronous data SRAM. It builds the MEM->WB bus and the MEM
// forwarding triple. A hold register freezes load data across a WB stall.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int StallBus     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    mem_wreg,
  output logic [4:0]              mem_waddr,
  output logic [31:0]             mem_wdata
);

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic [EX_TO_MEM_WD-1:0] r_reg;
  logic [EX_TO_MEM_WD-1:0] r_next;
  logic                    hold_valid_reg;
  logic [31:0]             hold_data_reg;

  // Decoded fields of the registered EX->MEM bus
  logic [31:0] ex_pc;
  logic [2:0]  mem_op;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;

  assign ex_pc        = r_reg[78:47];
  assign mem_op       = r_reg[46:44];
  assign data_ram_en  = r_reg[43];
  assign data_ram_wen = r_reg[42:39];
  assign sel_rf_res   = r_reg[38];
  assign rf_we        = r_reg[37];
  assign rf_waddr     = r_reg[36:32];
  assign ex_result    = r_reg[31:0];

  // Only the MEM and WB stall bits matter here.
  logic unused_stall;
  assign unused_stall = ^{stall[StallBus-1:5], stall[2:0]};

  logic        is_load;
  logic [31:0] rd;
  logic [1:0]  addr_lo;
  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] aligned_data;
  logic [31:0] rf_wdata;

  assign is_load = data_ram_en & (data_ram_wen == 4'b0000) & sel_rf_res;
  assign addr_lo = ex_result[1:0];

  // Once a stalled load captured its data, the SRAM output is no longer trusted.
  assign rd = hold_valid_reg ? hold_data_reg : data_sram_rdata;

  // Split read data into little-endian byte lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
    assign rd_byte[gi] = rd[8*gi +: 8];
  end

  assign sel_byte = rd_byte[addr_lo];
  assign sel_half = addr_lo[1] ? rd[31:16] : rd[15:0];

  // Next value of the input register: bubble, advance or hold.
  always_comb begin
    r_next = r_reg;
    if (stall[3] == Stop && stall[4] == NoStop) begin
      r_next = '0;
    end else if (stall[3] == NoStop) begin
      r_next = ex_to_mem_bus;
    end
  end

  // EX->MEM input register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg <= '0;
    end else begin
      r_reg <= r_next;
    end
  end

  // Freeze the first stalled cycle's SRAM data until WB accepts the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (stall[4] == Stop && !hold_valid_reg && is_load) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= data_sram_rdata;
    end else if (stall[4] == NoStop) begin
      hold_valid_reg <= 1'b0;
    end
  end

  // Load alignment and sign/zero extension; unknown ops behave as LW.
  always_comb begin
    aligned_data = rd;
    case (mem_op)
      OP_LB:   aligned_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  aligned_data = {24'h000000, sel_byte};
      OP_LH:   aligned_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  aligned_data = {16'h0000, sel_half};
      OP_LW:   aligned_data = rd;
      default: aligned_data = rd;
    endcase
  end

  // Final write-back value: loads take memory data, everything else ex_result.
  always_comb begin
    rf_wdata = is_load ? aligned_data : ex_result;
  end

  assign mem_to_wb_bus = {ex_pc, rf_we, rf_waddr, rf_wdata};
  assign mem_wreg      = rf_we;
  assign mem_waddr     = rf_waddr;
  assign mem_wdata     = rf_wdata;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between EX and WB in the 5-stage MIPS core.
- Registers the EX→MEM bus under stall control.
- Takes the synchronous data-SRAM read data for the load issued in EX, then byte/half-aligns and extends it.
- Produces the MEM→WB bus plus the MEM-stage forwarding triple for ID.
- Keeps a hold register so load data survives a downstream stall after the SRAM output has moved on.

Parameters:
- EX_TO_MEM_WD, 79, width of input bus. Layout: ex_pc[78:47], mem_op[46:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
- MEM_TO_WB_WD, 70, width of output bus. Layout: mem_pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0].
- StallBus, 6, stall vector width. Stop=1, NoStop=0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  StallBus  global stall vector; bit 3 = MEM input register, bit 4 = WB input register.
- ex_to_mem_bus  input  EX_TO_MEM_WD  EX results, layout above.
- data_sram_rdata  input  32  SRAM read data; valid in the cycle after EX issued the read.
- mem_to_wb_bus  output  MEM_TO_WB_WD  to WB stage.
- mem_wreg  output  1  forwarding: MEM instruction writes the register file.
- mem_waddr  output  5  forwarding: destination register.
- mem_wdata  output  32  forwarding: final write-back value (same as rf_wdata).

Behaviour:
- Input register r, priority order on posedge:
  - rst → 0.
  - else stall[3]==Stop && stall[4]==NoStop → 0 (bubble).
  - else stall[3]==NoStop → ex_to_mem_bus.
  - else hold current value.
- mem_op encoding: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU. Others are treated as LW.
- is_load = data_ram_en & (data_ram_wen==4'b0) & sel_rf_res.
- rd (effective read data) = hold_valid ? hold_data : data_sram_rdata.
- Alignment is little-endian; a = ex_result[1:0].
  - LB/LBU select rd[8a+7:8a].
  - LH/LHU select rd[15:0] if a[1]==0, else rd[31:16]; a[0] is ignored.
  - LW uses rd as-is; a is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- rf_wdata = is_load ? aligned_data : ex_result. It is combinational from r and rd, so there is zero added latency.
- Stores (wen≠0) and non-memory ops pass ex_result through unchanged. Stores produce no register write unless rf_we is set.
- Hold register, posedge:
  - rst → hold_valid=0, hold_data=0.
  - else stall[4]==Stop && hold_valid==0 && is_load → capture data_sram_rdata, hold_valid=1.
  - else stall[4]==NoStop → hold_valid=0.
  - Otherwise keep state.
  - Effect: the first stalled cycle's SRAM data is frozen for the whole stall, whatever data_sram_rdata does later.
- Bubble/reset state: r=0, so every output is 0 (mem_wreg=0, mem_waddr=0, mem_wdata=0, mem_to_wb_bus=0).
- Reset mid-stall: hold_valid clears and r clears on the same edge. There is no stale data carry-over.
- Forwarding outputs: mem_wreg=rf_we, mem_waddr=rf_waddr, mem_wdata=rf_wdata, taken from the current r.

Test Plan:
- LW, ex_result=0x1000, rdata=0xDEADBEEF, no stall → next cycle rf_wdata=0xDEADBEEF, mem_wreg=1, waddr as sent.
- LB, ex_result=0x1003, rdata=0x80112233 → rf_wdata=0xFFFFFF80. Same with LBU → 0x00000080.
- LH, ex_result=0x1002, rdata=0x8001_7FFF → 0xFFFF8001. LHU, ex_result=0x1000 → 0x00007FFF.
- LW in MEM with stall[4]=1, stall[3]=1 for 3 cycles while rdata changes 0x11111111→0x22222222→0x33333333 → rf_wdata stays 0x11111111 throughout. After release, hold_valid=0.
- stall[3]=1, stall[4]=0 → the instruction moves on; the next cycle has all outputs 0 (bubble).
- ADD result 0x00000005, rf_we=1 → rf_wdata=0x5 with rdata ignored. rst asserted mid-stall → all outputs 0 next cycle.
